// File: rtl/gbe_pkt_pkg.sv
// Shared types and helpers for the GbE TX packetizer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gbe_pkt_pkg;

  // Packet FSM states; HDR is only reachable when the sequence-header build option is on.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } pkt_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

  localparam byte_idx_t BYTE_IDX_LAST = byte_idx_t'(BYTES_PER_WORD - 1);

  // Increment that sticks at all-ones for a counter 'width' bits wide (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val == max_val) ? val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/gbe_word_serializer.sv
// Holds one 32-bit user word and hands its bytes out MSB-first, one per cycle.
// Latency: a word accepted into an empty holder offers byte 0 in the accept cycle itself.
// Backpressure: afull_i freezes the byte index; a new word is taken only when empty or on byte 3.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   rdy_en_i             global ready enable (low for one cycle after reset)
//   hold_block_i         suppress all emission and acceptance (header phase)
//   direct_block_i       suppress emitting byte 0 straight from in_data_i on accept
//   in_data/valid/last_i upstream word; in_ready_o / acc_o handshake
//   afull_i              downstream almost full
//   emit_o/emit_byte_o   a byte leaves the holder this cycle
//   word_done_o          the emitted byte is byte 3 of the held word
//   word_last_o          in_last flag of the held word
module gbe_word_serializer
  import gbe_pkt_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rdy_en_i,
  input  logic        hold_block_i,
  input  logic        direct_block_i,
  input  logic [31:0] in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        in_ready_o,
  output logic        acc_o,
  input  logic        afull_i,
  output logic        emit_o,
  output logic [7:0]  emit_byte_o,
  output logic        word_done_o,
  output logic        word_last_o
);

  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic        hold_vld_q, hold_vld_d;
  byte_idx_t   idx_q, idx_d;
  logic        idx_at_last;
  logic        hold_emit;
  logic        direct_emit;

  always_comb begin
    idx_at_last = (idx_q == BYTE_IDX_LAST);
    in_ready_o  = rdy_en_i && !hold_block_i && (!hold_vld_q || (idx_at_last && !afull_i));
    acc_o       = in_valid_i && in_ready_o;
    hold_emit   = hold_vld_q && !afull_i && !hold_block_i;
    // An empty holder lets byte 0 go out in the accept cycle, giving 1-cycle latency.
    direct_emit = !hold_vld_q && acc_o && !afull_i && !direct_block_i;
    emit_o      = hold_emit || direct_emit;
    word_done_o = hold_emit && idx_at_last;
    word_last_o = last_q;

    emit_byte_o = in_data_i[31:24];
    if (hold_vld_q) begin
      case (idx_q)
        2'd0:    emit_byte_o = word_q[31:24];
        2'd1:    emit_byte_o = word_q[23:16];
        2'd2:    emit_byte_o = word_q[15:8];
        default: emit_byte_o = word_q[7:0];
      endcase
    end

    word_d     = word_q;
    last_d     = last_q;
    hold_vld_d = hold_vld_q;
    idx_d      = idx_q;
    if (!hold_vld_q) begin
      if (acc_o) begin
        word_d     = in_data_i;
        last_d     = in_last_i;
        hold_vld_d = 1'b1;
        idx_d      = direct_emit ? byte_idx_t'(1) : byte_idx_t'(0);
      end
    end else if (hold_emit) begin
      if (idx_at_last) begin
        idx_d = '0;
        // Back-to-back: the next word drops in as byte 3 of the current one leaves.
        if (acc_o) begin
          word_d = in_data_i;
          last_d = in_last_i;
        end else begin
          hold_vld_d = 1'b0;
        end
      end else begin
        idx_d = idx_q + byte_idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q     <= '0;
      last_q     <= 1'b0;
      hold_vld_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      word_q     <= word_d;
      last_q     <= last_d;
      hold_vld_q <= hold_vld_d;
      idx_q      <= idx_d;
    end
  end

endmodule

// File: rtl/gbe_tx_packetizer.sv
// Serializes 32-bit user words into the UDP core app_tx byte stream, framing packets with eof.
// Latency: byte 0 of a word accepted into an idle packetizer appears on app_tx_dvld 1 cycle later.
// Backpressure: app_tx_afull stalls emission (mid-word allowed); in_ready drops while stalled.
//
// Build option: define GBE_PKT_SEQ_HDR_EN to prefix every packet with a 4-byte big-endian
// sequence number (starts at 0 after reset, +1 per packet).
//
// Ports:
//   app_clk, app_rst            clock, synchronous active-high reset
//   in_data/valid/last, in_ready  user word stream (byte [31:24] first)
//   cfg_destip, cfg_destport    destination, captured on the first word of each packet
//   app_tx_data/dvld/eof        registered byte stream to the UDP core
//   app_tx_destip/destport      destination, constant from first byte through eof
//   app_tx_afull, app_tx_overflow  UDP core TX FIFO status
//   pkt_count, ovf_count        saturating packet / overflow-edge counters
module gbe_tx_packetizer
  import gbe_pkt_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             app_clk,
  input  logic             app_rst,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [31:0]      cfg_destip,
  input  logic [15:0]      cfg_destport,
  output logic [7:0]       app_tx_data,
  output logic             app_tx_dvld,
  output logic             app_tx_eof,
  output logic [31:0]      app_tx_destip,
  output logic [15:0]      app_tx_destport,
  input  logic             app_tx_afull,
  input  logic             app_tx_overflow,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int WCNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MAX_WORDS - 1);

`ifdef GBE_PKT_SEQ_HDR_EN
  localparam pkt_state_e FIRST_STATE = ST_HDR;
`else
  localparam pkt_state_e FIRST_STATE = ST_DATA;
`endif

  pkt_state_e        state_q, state_d;
  logic              rdy_en_q;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]        data_q, data_d;
  logic              dvld_q, dvld_d;
  logic              eof_q, eof_d;
  logic [31:0]       destip_q, destip_d, pend_ip_q, pend_ip_d;
  logic [15:0]       destport_q, destport_d, pend_port_q, pend_port_d;
  logic              first_pend_q, first_pend_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d, ovf_cnt_q, ovf_cnt_d;
  logic              ovf_prev_q;

  logic              hold_block, direct_block;
  logic              ser_acc, ser_emit, ser_word_done, ser_word_last;
  logic [7:0]        ser_byte;
  logic              hdr_emit;
  logic [7:0]        hdr_byte;
  logic              eof_now, pkt_start;

`ifdef GBE_PKT_SEQ_HDR_EN
  logic [31:0]       seq_q, seq_d;
  byte_idx_t         hdr_idx_q, hdr_idx_d;
  // Payload bytes wait in the holder until the header has gone out.
  assign direct_block = (state_q == ST_IDLE);
`else
  assign direct_block = 1'b0;
`endif
  assign hold_block = (state_q == ST_HDR);

  gbe_word_serializer u_ser (
    .clk_i          (app_clk),
    .rst_i          (app_rst),
    .rdy_en_i       (rdy_en_q),
    .hold_block_i   (hold_block),
    .direct_block_i (direct_block),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_last_i      (in_last),
    .in_ready_o     (in_ready),
    .acc_o          (ser_acc),
    .afull_i        (app_tx_afull),
    .emit_o         (ser_emit),
    .emit_byte_o    (ser_byte),
    .word_done_o    (ser_word_done),
    .word_last_o    (ser_word_last)
  );

  always_comb begin
    hdr_emit = 1'b0;
    hdr_byte = 8'h00;
`ifdef GBE_PKT_SEQ_HDR_EN
    seq_d     = seq_q;
    hdr_idx_d = hdr_idx_q;
    hdr_emit  = (state_q == ST_HDR) && !app_tx_afull;
    case (hdr_idx_q)
      2'd0:    hdr_byte = seq_q[31:24];
      2'd1:    hdr_byte = seq_q[23:16];
      2'd2:    hdr_byte = seq_q[15:8];
      default: hdr_byte = seq_q[7:0];
    endcase
    if (hdr_emit) begin
      hdr_idx_d = hdr_idx_q + byte_idx_t'(1);
      if (hdr_idx_q == BYTE_IDX_LAST) seq_d = seq_q + 32'd1;
    end
`endif

    dvld_d  = hdr_emit || ser_emit;
    data_d  = hdr_emit ? hdr_byte : (ser_emit ? ser_byte : 8'h00);
    eof_now = ser_word_done && (ser_word_last || (wcnt_q == WCNT_LAST));
    eof_d   = eof_now;
    // The first word of a packet arrives either from idle or in the same cycle as the eof byte.
    pkt_start = ser_acc && ((state_q == ST_IDLE) || eof_now);

    wcnt_d = wcnt_q;
    if (eof_now)            wcnt_d = '0;
    else if (ser_word_done) wcnt_d = wcnt_q + WCNT_W'(1);

    // The new destination is staged at accept and only shown with the packet's first byte,
    // so the previous packet's eof byte still carries its own destination.
    destip_d     = destip_q;
    destport_d   = destport_q;
    pend_ip_d    = pend_ip_q;
    pend_port_d  = pend_port_q;
    first_pend_d = first_pend_q;
    if (dvld_d && first_pend_q) begin
      destip_d     = pend_ip_q;
      destport_d   = pend_port_q;
      first_pend_d = 1'b0;
    end
    if (pkt_start) begin
      if ((state_q == ST_IDLE) && dvld_d) begin
        destip_d   = cfg_destip;
        destport_d = cfg_destport;
      end else begin
        pend_ip_d    = cfg_destip;
        pend_port_d  = cfg_destport;
        first_pend_d = 1'b1;
      end
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ser_acc) state_d = FIRST_STATE;
      ST_HDR:  if (hdr_emit && (hdr_byte_last())) state_d = ST_DATA;
      ST_DATA: if (eof_now) state_d = ser_acc ? FIRST_STATE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    pkt_cnt_d = eof_now ? CNT_W'(sat_inc(32'(pkt_cnt_q), CNT_W)) : pkt_cnt_q;
    ovf_cnt_d = (app_tx_overflow && !ovf_prev_q) ? CNT_W'(sat_inc(32'(ovf_cnt_q), CNT_W)) : ovf_cnt_q;
  end

  // True on the final header byte; constant false when the header option is off.
  function automatic logic hdr_byte_last();
`ifdef GBE_PKT_SEQ_HDR_EN
    return (hdr_idx_q == BYTE_IDX_LAST);
`else
    return 1'b0;
`endif
  endfunction

  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state_q      <= ST_IDLE;
      rdy_en_q     <= 1'b0;
      wcnt_q       <= '0;
      data_q       <= '0;
      dvld_q       <= 1'b0;
      eof_q        <= 1'b0;
      destip_q     <= '0;
      destport_q   <= '0;
      pend_ip_q    <= '0;
      pend_port_q  <= '0;
      first_pend_q <= 1'b0;
      pkt_cnt_q    <= '0;
      ovf_cnt_q    <= '0;
      ovf_prev_q   <= 1'b0;
`ifdef GBE_PKT_SEQ_HDR_EN
      seq_q        <= '0;
      hdr_idx_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rdy_en_q     <= 1'b1;
      wcnt_q       <= wcnt_d;
      data_q       <= data_d;
      dvld_q       <= dvld_d;
      eof_q        <= eof_d;
      destip_q     <= destip_d;
      destport_q   <= destport_d;
      pend_ip_q    <= pend_ip_d;
      pend_port_q  <= pend_port_d;
      first_pend_q <= first_pend_d;
      pkt_cnt_q    <= pkt_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_prev_q   <= app_tx_overflow;
`ifdef GBE_PKT_SEQ_HDR_EN
      seq_q        <= seq_d;
      hdr_idx_q    <= hdr_idx_d;
`endif
    end
  end

  assign app_tx_data     = data_q;
  assign app_tx_dvld     = dvld_q;
  assign app_tx_eof      = eof_q;
  assign app_tx_destip   = destip_q;
  assign app_tx_destport = destport_q;
  assign pkt_count       = pkt_cnt_q;
  assign ovf_count       = ovf_cnt_q;

endmodule

// File: tb/tb_gbe_tx_packetizer.sv
// Self-checking bench for gbe_tx_packetizer (MAX_WORDS=4); expected bytes go to a scoreboard
// queue when a word is handed over and are popped as the DUT emits them.
// Works with or without GBE_PKT_SEQ_HDR_EN defined.
module tb_gbe_tx_packetizer;

  localparam int MAX_WORDS = 4;
  localparam int CNT_W     = 16;
`ifdef GBE_PKT_SEQ_HDR_EN
  localparam int HDR_B   = 4;
  localparam int HDR_LAT = 1;
`else
  localparam int HDR_B   = 0;
  localparam int HDR_LAT = 0;
`endif

  logic             clk = 1'b0;
  logic             app_rst;
  logic [31:0]      in_data;
  logic             in_valid, in_last, in_ready;
  logic [31:0]      cfg_destip;
  logic [15:0]      cfg_destport;
  logic [7:0]       app_tx_data;
  logic             app_tx_dvld, app_tx_eof;
  logic [31:0]      app_tx_destip;
  logic [15:0]      app_tx_destport;
  logic             app_tx_afull, app_tx_overflow;
  logic [CNT_W-1:0] pkt_count, ovf_count;

  always #5 clk = ~clk;

  gbe_tx_packetizer #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .app_clk(clk), .app_rst(app_rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .cfg_destip(cfg_destip), .cfg_destport(cfg_destport),
    .app_tx_data(app_tx_data), .app_tx_dvld(app_tx_dvld), .app_tx_eof(app_tx_eof),
    .app_tx_destip(app_tx_destip), .app_tx_destport(app_tx_destport),
    .app_tx_afull(app_tx_afull), .app_tx_overflow(app_tx_overflow),
    .pkt_count(pkt_count), .ovf_count(ovf_count)
  );

  typedef struct packed {
    logic [7:0]  data;
    logic        eof;
    logic [31:0] ip;
    logic [15:0] port;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   byte_cnt = 0;
  int   acc_cyc = 0;
  logic af_prev = 1'b0;

  // Reference model of packet framing
  logic        m_open = 1'b0;
  int          m_wcnt = 0;
  logic [31:0] m_seq = '0;
  logic [31:0] m_ip = '0;
  logic [15:0] m_port = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_open = 1'b0;
    m_wcnt = 0;
    m_seq  = '0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic last);
    logic eof_w;
    if (!m_open) begin
      m_ip   = cfg_destip;
      m_port = cfg_destport;
      m_open = 1'b1;
`ifdef GBE_PKT_SEQ_HDR_EN
      for (int b = 0; b < 4; b++) exp_q.push_back({m_seq[31-8*b -: 8], 1'b0, m_ip, m_port});
      m_seq = m_seq + 32'd1;
`endif
    end
    eof_w = last || (m_wcnt == MAX_WORDS - 1);
    for (int b = 0; b < 4; b++) exp_q.push_back({w[31-8*b -: 8], eof_w && (b == 3), m_ip, m_port});
    if (eof_w) begin
      m_open = 1'b0;
      m_wcnt = 0;
    end else begin
      m_wcnt++;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (af_prev) check_val("dvld_after_afull", 64'(app_tx_dvld), 64'd0);
    if (app_tx_dvld) begin
      cyc_log.push_back(cyc);
      byte_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_byte", 64'(app_tx_dvld), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("byte_data", 64'(app_tx_data), 64'(e.data));
        check_val("byte_eof", 64'(app_tx_eof), 64'(e.eof));
        check_val("byte_destip", 64'(app_tx_destip), 64'(e.ip));
        check_val("byte_destport", 64'(app_tx_destport), 64'(e.port));
      end
    end else if (app_tx_eof) begin
      check_val("eof_without_dvld", 64'(app_tx_eof), 64'd0);
    end
    af_prev = app_tx_afull;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge on which the word transferred.
  task automatic send_word(input logic [31:0] w, input logic last);
    int n = 0;
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 500) break;
    end
    if (n > 500) begin
      check_val("send_timeout", 64'(in_ready), 64'd1);
    end else begin
      acc_cyc = cyc;
      push_word(w, last);
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input string tag);
    int n = 0;
    while (byte_cnt < target && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val(tag, 64'(byte_cnt >= target), 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_val(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int b;
    int p0;
    app_rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    cfg_destip = '0; cfg_destport = '0; app_tx_afull = 1'b0; app_tx_overflow = 1'b0;

    // Reset state and ready release timing
    repeat (3) step();
    @(negedge clk);
    check_val("rst_in_ready", 64'(in_ready), 64'd0);
    check_val("rst_dvld", 64'(app_tx_dvld), 64'd0);
    check_val("rst_eof", 64'(app_tx_eof), 64'd0);
    check_val("rst_data", 64'(app_tx_data), 64'd0);
    check_val("rst_destip", 64'(app_tx_destip), 64'd0);
    check_val("rst_pkt_count", 64'(pkt_count), 64'd0);
    check_val("rst_ovf_count", 64'(ovf_count), 64'd0);
    step();
    app_rst = 1'b0;
    @(negedge clk);
    check_val("ready_still_low", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    check_val("ready_after_release", 64'(in_ready), 64'd1);
    step();

    // 1: three back-to-back words, one packet
    cfg_destip = 32'h0A00_0001; cfg_destport = 16'd1234;
    b = byte_cnt;
    send_word(32'h0102_0304, 1'b0);
    p0 = acc_cyc;
    send_word(32'h0506_0708, 1'b0);
    send_word(32'h090A_0B0C, 1'b1);
    wait_drain("t1_drain");
    check_val("t1_first_latency", 64'(cyc_log[b] - p0), 64'(1 + HDR_LAT));
    check_val("t1_contiguous", 64'(cyc_log[b + 11 + HDR_B] - cyc_log[b]), 64'(11 + HDR_B));
    check_val("t1_pkt_count", 64'(pkt_count), 64'd1);
    step();

    // 2: afull stall for 5 cycles mid-word
    cfg_destip = 32'h0A00_0003; cfg_destport = 16'd77;
    b = byte_cnt;
    fork
      begin
        send_word(32'hA1A2_A3A4, 1'b0);
        send_word(32'hB1B2_B3B4, 1'b1);
      end
      begin
        wait_bytes(b + 2, "t2_first_bytes");
        step();
        app_tx_afull = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        app_tx_afull = 1'b0;
      end
    join
    wait_drain("t2_drain");
    check_val("t2_stall_span", 64'(cyc_log[b + 7 + HDR_B] - cyc_log[b]), 64'(7 + HDR_B + 5));
    check_val("t2_pkt_count", 64'(pkt_count), 64'd2);
    step();

    // 3: 10 words with a single last flag -> forced splits at MAX_WORDS
    cfg_destip = 32'h0A00_0004; cfg_destport = 16'd88;
    for (int i = 1; i <= 10; i++) send_word({8'(i), 8'(i + 16), 8'(i + 32), 8'(i + 48)}, i == 10);
    wait_drain("t3_drain");
    check_val("t3_pkt_count", 64'(pkt_count), 64'd5);
    step();

    // 4: destination changed mid-packet is ignored until the next packet
    cfg_destip = 32'h0A00_0001; cfg_destport = 16'h1111;
    send_word(32'hC0C1_C2C3, 1'b0);
    cfg_destip = 32'h0A00_0002; cfg_destport = 16'h2222;
    send_word(32'hC4C5_C6C7, 1'b0);
    send_word(32'hC8C9_CACB, 1'b1);
    send_word(32'hD0D1_D2D3, 1'b1);
    wait_drain("t4_drain");
    check_val("t4_destip_final", 64'(app_tx_destip), 64'h0A00_0002);
    check_val("t4_pkt_count", 64'(pkt_count), 64'd7);
    step();

    // 5: overflow edges, then reset in the middle of a word
    for (int i = 0; i < 3; i++) begin
      app_tx_overflow = 1'b1; step(); step();
      app_tx_overflow = 1'b0; step(); step();
    end
    @(negedge clk);
    check_val("t5_ovf_count", 64'(ovf_count), 64'd3);
    step();
    b = byte_cnt;
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_bytes(b + 2, "t5_partial_bytes");
    step();
    app_rst = 1'b1;
    step();
    model_reset();
    @(negedge clk);
    check_val("t5_rst_dvld", 64'(app_tx_dvld), 64'd0);
    check_val("t5_rst_eof", 64'(app_tx_eof), 64'd0);
    check_val("t5_rst_data", 64'(app_tx_data), 64'd0);
    check_val("t5_rst_destip", 64'(app_tx_destip), 64'd0);
    check_val("t5_rst_destport", 64'(app_tx_destport), 64'd0);
    check_val("t5_rst_pkt_count", 64'(pkt_count), 64'd0);
    check_val("t5_rst_ovf_count", 64'(ovf_count), 64'd0);
    check_val("t5_rst_in_ready", 64'(in_ready), 64'd0);
    step();
    app_rst = 1'b0;
    step(); step();

    // 6: two one-word packets after reset (sequence header restarts at 0 when enabled)
    cfg_destip = 32'hC0A8_0001; cfg_destport = 16'h3333;
    send_word(32'h1122_3344, 1'b1);
    send_word(32'h5566_7788, 1'b1);
    wait_drain("t6_drain");
    check_val("t6_pkt_count", 64'(pkt_count), 64'd2);
    step(); step();
    check_val("end_no_trailing_dvld", 64'(app_tx_dvld), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
